// File: rtl/pair_code_decoder_if.sv
// rtl/pair_code_decoder_if.sv - code input and decoded output handshake bundle for pair_code_decoder
interface pair_code_decoder_if;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] code;
    logic       out_valid;
    logic       out_ready;
    logic       a;
    logic       b;
    logic       code_err;

    modport master (
        output in_valid, code, out_ready,
        input  in_ready, out_valid, a, b, code_err
    );

    modport slave (
        input  in_valid, code, out_ready,
        output in_ready, out_valid, a, b, code_err
    );
endinterface

// File: rtl/pair_code_decoder.sv
// rtl/pair_code_decoder.sv - pair code receiver: decode, illegal-code flag, error count, hunt/sync/lock FSM
module pair_code_decoder #(
    parameter int CNT_W    = 8,
    parameter int LOCK_N   = 4,
    parameter int UNLOCK_M = 2
) (
    input  logic             clk,
    input  logic             clr,
    pair_code_decoder_if.slave bus,
    input  logic             err_clear,
    output logic             locked,
    output logic [CNT_W-1:0] err_count
);
    localparam int GW = $clog2(LOCK_N + 1);
    localparam int BW = $clog2(UNLOCK_M + 1);

    typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;

    state_t           r_state;
    logic [GW-1:0]    r_good;
    logic [BW-1:0]    r_bad;
    logic             r_locked;
    logic             r_out_valid;
    logic             r_a;
    logic             r_b;
    logic             r_code_err;
    logic [CNT_W-1:0] r_err_count;

    logic w_legal;
    logic w_in_ready;
    logic w_accept;
    logic w_illegal_acc;

    always_comb begin
        w_legal = (bus.code == 4'b0000) || (bus.code == 4'b0110) ||
                  (bus.code == 4'b1100) || (bus.code == 4'b1001);
    end

    assign w_in_ready    = ~r_out_valid | bus.out_ready;
    assign w_accept      = bus.in_valid & w_in_ready;
    assign w_illegal_acc = w_accept & ~w_legal;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state  <= HUNT;
            r_good   <= '0;
            r_bad    <= '0;
            r_locked <= 1'b0;
        end else if (w_accept) begin
            case (r_state)
                HUNT: begin
                    if (w_legal) begin
                        r_state <= SYNC;
                        r_good  <= GW'(1);
                    end
                end
                SYNC: begin
                    if (!w_legal) begin
                        r_state <= HUNT;
                        r_good  <= '0;
                    end else if (r_good == GW'(LOCK_N - 1)) begin
                        r_state  <= LOCKED;
                        r_good   <= '0;
                        r_locked <= 1'b1;
                    end else begin
                        r_good <= r_good + GW'(1);
                    end
                end
                LOCKED: begin
                    if (w_legal) begin
                        r_bad <= '0;
                    end else if (r_bad == BW'(UNLOCK_M - 1)) begin
                        r_state  <= HUNT;
                        r_bad    <= '0;
                        r_locked <= 1'b0;
                    end else begin
                        r_bad <= r_bad + BW'(1);
                    end
                end
                default: begin
                    r_state  <= HUNT;
                    r_good   <= '0;
                    r_bad    <= '0;
                    r_locked <= 1'b0;
                end
            endcase
        end
    end

    // Forwarding decision uses the pre-accept state, so the unlocking word is still delivered.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_out_valid <= 1'b0;
            r_a         <= 1'b0;
            r_b         <= 1'b0;
            r_code_err  <= 1'b0;
        end else if (w_accept && (r_state == LOCKED)) begin
            r_out_valid <= 1'b1;
            r_a         <= w_legal & (bus.code[0] | bus.code[1]);
            r_b         <= w_legal & bus.code[3];
            r_code_err  <= ~w_legal;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_err_count <= '0;
        end else if (err_clear) begin
            r_err_count <= w_illegal_acc ? CNT_W'(1) : '0;
        end else if (w_illegal_acc && (r_err_count != {CNT_W{1'b1}})) begin
            r_err_count <= r_err_count + CNT_W'(1);
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.a         = r_a;
    assign bus.b         = r_b;
    assign bus.code_err  = r_code_err;
    assign locked        = r_locked;
    assign err_count     = r_err_count;
endmodule

// File: tb/tb_pair_code_decoder.sv
// tb/tb_pair_code_decoder.sv - directed self-checking bench for pair_code_decoder
module tb_pair_code_decoder;
    logic       clk;
    logic       clr;
    logic       err_clear1;
    logic       locked1;
    logic [7:0] err_count1;
    logic       err_clear2;
    logic       locked2;
    logic [1:0] err_count2;

    int checks = 0;
    int errors = 0;

    pair_code_decoder_if if1 ();
    pair_code_decoder_if if2 ();

    pair_code_decoder #(.CNT_W(8), .LOCK_N(4), .UNLOCK_M(2)) dut1 (
        .clk       (clk),
        .clr       (clr),
        .bus       (if1.slave),
        .err_clear (err_clear1),
        .locked    (locked1),
        .err_count (err_count1)
    );

    pair_code_decoder #(.CNT_W(2), .LOCK_N(4), .UNLOCK_M(2)) dut2 (
        .clk       (clk),
        .clr       (clr),
        .bus       (if2.slave),
        .err_clear (err_clear2),
        .locked    (locked2),
        .err_count (err_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send1(input logic [3:0] c);
        if1.in_valid = 1'b1;
        if1.code     = c;
        @(posedge clk);
        #1;
        if1.in_valid = 1'b0;
    endtask

    task automatic send2(input logic [3:0] c);
        if2.in_valid = 1'b1;
        if2.code     = c;
        @(posedge clk);
        #1;
        if2.in_valid = 1'b0;
    endtask

    task automatic check_word(input string tag, input logic ov, input logic ea, input logic eb, input logic ee);
        check({tag, "_ov"}, if1.out_valid, ov);
        check({tag, "_a"},  if1.a,  ea);
        check({tag, "_b"},  if1.b,  eb);
        check({tag, "_err"}, if1.code_err, ee);
    endtask

    initial begin
        clr = 1'b0;
        err_clear1 = 1'b0;
        err_clear2 = 1'b0;
        if1.in_valid = 1'b0; if1.code = 4'h0; if1.out_ready = 1'b1;
        if2.in_valid = 1'b0; if2.code = 4'h0; if2.out_ready = 1'b1;
        #12;
        check_word("rst", 1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_locked", locked1, 1'b0);
        check("rst_cnt", err_count1, 8'd0);
        check("rst_in_ready", if1.in_ready, 1'b1);
        clr = 1'b1;
        @(posedge clk); #1;

        // Test 1: lock acquisition, nothing forwarded while hunting/syncing
        send1(4'b0000); check("t1_ov0", if1.out_valid, 1'b0); check("t1_lk0", locked1, 1'b0);
        send1(4'b0110); check("t1_ov1", if1.out_valid, 1'b0); check("t1_lk1", locked1, 1'b0);
        send1(4'b1100); check("t1_ov2", if1.out_valid, 1'b0); check("t1_lk2", locked1, 1'b0);
        send1(4'b1001); check("t1_ov3", if1.out_valid, 1'b0); check("t1_lk3", locked1, 1'b1);
        send1(4'b1001); check_word("t1_w", 1'b1, 1'b1, 1'b1, 1'b0);
        @(posedge clk); #1; check("t1_drain", if1.out_valid, 1'b0);

        // Test 2: back-to-back forwarding
        send1(4'b0110); check_word("t2_w0", 1'b1, 1'b1, 1'b0, 1'b0); check("t2_rdy0", if1.in_ready, 1'b1);
        send1(4'b1100); check_word("t2_w1", 1'b1, 1'b0, 1'b1, 1'b0); check("t2_rdy1", if1.in_ready, 1'b1);
        send1(4'b0000); check_word("t2_w2", 1'b1, 1'b0, 1'b0, 1'b0); check("t2_rdy2", if1.in_ready, 1'b1);
        @(posedge clk); #1; check("t2_drain", if1.out_valid, 1'b0);

        // Test 3: backpressure holds the word and stalls input
        if1.out_ready = 1'b0;
        send1(4'b0110); check_word("t3_w0", 1'b1, 1'b1, 1'b0, 1'b0); check("t3_rdy0", if1.in_ready, 1'b0);
        send1(4'b1100); check_word("t3_h1", 1'b1, 1'b1, 1'b0, 1'b0); check("t3_rdy1", if1.in_ready, 1'b0);
        send1(4'b1100); check_word("t3_h2", 1'b1, 1'b1, 1'b0, 1'b0); check("t3_rdy2", if1.in_ready, 1'b0);
        if1.out_ready = 1'b1;
        #1; check("t3_rdy_rel", if1.in_ready, 1'b1);
        send1(4'b1100); check_word("t3_w1", 1'b1, 1'b0, 1'b1, 1'b0);
        @(posedge clk); #1; check("t3_nodup", if1.out_valid, 1'b0);

        // Test 4: loss of lock after UNLOCK_M consecutive illegal codes
        send1(4'b1111); check_word("t4_w0", 1'b1, 1'b0, 1'b0, 1'b1); check("t4_lk0", locked1, 1'b1);
        send1(4'b0110); check_word("t4_w1", 1'b1, 1'b1, 1'b0, 1'b0); check("t4_lk1", locked1, 1'b1);
        send1(4'b1111); check("t4_lk2", locked1, 1'b1);
        send1(4'b1111); check_word("t4_w3", 1'b1, 1'b0, 1'b0, 1'b1); check("t4_lk3", locked1, 1'b0);
        check("t4_cnt", err_count1, 8'd3);
        send1(4'b0000); check("t4_hunt_drop", if1.out_valid, 1'b0);

        // Test 6: async reset while holding a word in LOCKED
        send1(4'b0110); send1(4'b1100); send1(4'b1001);
        check("t6_lk", locked1, 1'b1);
        if1.out_ready = 1'b0;
        send1(4'b1001); check("t6_ov", if1.out_valid, 1'b1);
        #2; clr = 1'b0;
        #1;
        check("t6_rst_ov", if1.out_valid, 1'b0);
        check("t6_rst_lk", locked1, 1'b0);
        check("t6_rst_cnt", err_count1, 8'd0);
        if1.out_ready = 1'b1;
        #2; clr = 1'b1;
        send1(4'b0000); send1(4'b0110); send1(4'b1100);
        check("t6_relock3", locked1, 1'b0);
        send1(4'b1001);
        check("t6_relock4", locked1, 1'b1);
        check("t6_relock_ov", if1.out_valid, 1'b0);

        // Test 5: saturating counter with CNT_W=2 and clear priority
        send2(4'b1111); check("t5_c1", err_count2, 2'd1);
        send2(4'b0011); check("t5_c2", err_count2, 2'd2);
        send2(4'b1010); check("t5_c3", err_count2, 2'd3);
        send2(4'b0001); check("t5_c4", err_count2, 2'd3);
        send2(4'b1000); check("t5_c5", err_count2, 2'd3);
        err_clear2 = 1'b1;
        send2(4'b0101); check("t5_clr_ill", err_count2, 2'd1);
        @(posedge clk); #1; check("t5_clr_only", err_count2, 2'd0);
        err_clear2 = 1'b0;
        send2(4'b0000); check("t5_legal", err_count2, 2'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
